// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle between vga_sync_gen (master) and display consumers (slave).
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_sync_gen_if;
  logic       en;
  logic       pix_tick;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_end;
  logic       frame_end;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  modport master (
    input  en,
    output pix_tick, hcount, vcount, hsync, vsync, video_on, line_end, frame_end, frame_cnt
  );

  modport slave (
    output en,
    input  pix_tick, hcount, vcount, hsync, vsync, video_on, line_end, frame_end, frame_cnt
  );
`else
  modport master (
    input  en,
    output pix_tick, hcount, vcount, hsync, vsync, video_on, line_end, frame_end
  );

  modport slave (
    output en,
    input  pix_tick, hcount, vcount, hsync, vsync, video_on, line_end, frame_end
  );
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// Raster timing source: clock divider to pixel rate, h/v position counters, zero-lag registered syncs.
// Define VGA_FRAME_CNT_EN to add a 16-bit wrapping completed-frame counter.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             pix_tick;
  logic             line_end;
  logic             frame_end;

  assign pix_tick  = vga.en && (div_cnt_q == DIV_LAST);
  assign line_end  = pix_tick && (hcount_q == H_LAST);
  assign frame_end = line_end && (vcount_q == V_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    if (vga.en) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    end
    if (pix_tick) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
    // Decoding the next-state counters keeps the registered syncs aligned with hcount/vcount.
    hsync_d    = ((hcount_d >= HS_START) && (hcount_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = ((vcount_d >= VS_START) && (vcount_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    video_on_d = (hcount_d < H_VIS) && (vcount_d < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      hcount_q   <= '0;
      vcount_q   <= '0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      video_on_q <= 1'b1;
    end else begin
      div_cnt_q  <= div_cnt_d;
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign vga.pix_tick  = pix_tick;
  assign vga.hcount    = hcount_q;
  assign vga.vcount    = vcount_q;
  assign vga.hsync     = hsync_q;
  assign vga.vsync     = vsync_q;
  assign vga.video_on  = video_on_q;
  assign vga.line_end  = line_end;
  assign vga.frame_end = frame_end;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance for line/enable/reset, small-timing instance for frames.
module tb_vga_sync_gen;
  logic clk  = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if a ();
  vga_sync_gen_if b ();

  vga_sync_gen u0 (.clk(clk), .rst(rst0), .vga(a.master));

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(1),  .SYNC_POL(1'b0)
  ) u1 (.clk(clk), .rst(rst1), .vga(b.master));

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       von;
    logic       le;
    logic       fe;
  } exp_t;

  exp_t sbq[$];
  bit   mon_on = 1'b0;
  int   hs_low_ticks = 0;
  int   le_ticks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference raster for 640x480@60 timing with active-low syncs.
  function automatic exp_t model(input int h, input int v);
    exp_t e;
    e.h   = 10'(h);
    e.v   = 10'(v);
    e.hs  = !(h >= 656 && h < 752);
    e.vs  = !(v >= 490 && v < 492);
    e.von = (h < 640) && (v < 480);
    e.le  = (h == 799);
    e.fe  = (h == 799) && (v == 524);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_on && a.pix_tick) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_tick", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        chk("sb_hcount",    32'(a.hcount),    32'(e.h));
        chk("sb_vcount",    32'(a.vcount),    32'(e.v));
        chk("sb_hsync",     32'(a.hsync),     32'(e.hs));
        chk("sb_vsync",     32'(a.vsync),     32'(e.vs));
        chk("sb_video_on",  32'(a.video_on),  32'(e.von));
        chk("sb_line_end",  32'(a.line_end),  32'(e.le));
        chk("sb_frame_end", 32'(a.frame_end), 32'(e.fe));
        if (!a.hsync) hs_low_ticks++;
        if (a.line_end) le_ticks++;
      end
    end
  end

  initial begin
    int n;
    int fe_n, le_n, vsl_n, hsl_n, von_n;
    a.en = 1'b1;
    b.en = 1'b0;

    // Reset held three clocks, released with en high.
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0;
    chk("rst_hcount",    32'(a.hcount),    32'd0);
    chk("rst_vcount",    32'(a.vcount),    32'd0);
    chk("rst_video_on",  32'(a.video_on),  32'd1);
    chk("rst_hsync",     32'(a.hsync),     32'd1);
    chk("rst_vsync",     32'(a.vsync),     32'd1);
    chk("rst_pix_tick",  32'(a.pix_tick),  32'd0);
    chk("rst_line_end",  32'(a.line_end),  32'd0);
    chk("rst_frame_end", 32'(a.frame_end), 32'd0);

    // One full line plus the first pixel of line 1 through the scoreboard.
    for (int h = 0; h < 800; h++) sbq.push_back(model(h, 0));
    sbq.push_back(model(0, 1));
    mon_on = 1'b1;
    @(posedge clk);
    #1 chk("first_tick_after_1st_edge", 32'(a.pix_tick), 32'd1);
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("line_sb_drained", 32'(sbq.size()), 32'd0);
    mon_on = 1'b0;
    chk("line_hsync_low_ticks", 32'(hs_low_ticks), 32'd96);
    chk("line_end_pulses",      32'(le_ticks),     32'd1);

    // Freeze at hcount=100 for ten clocks.
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (a.hcount != 10'd100 && n < 400);
    chk("reach_h100",  32'(a.hcount),    32'd100);
    chk("div_at_h100", 32'(u0.div_cnt_q), 32'd0);
    a.en = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      chk("frz_pix_tick", 32'(a.pix_tick),    32'd0);
      chk("frz_hcount",   32'(a.hcount),      32'd100);
      chk("frz_vcount",   32'(a.vcount),      32'd1);
      chk("frz_hsync",    32'(a.hsync),       32'd1);
      chk("frz_line_end", 32'(a.line_end),    32'd0);
      chk("frz_div_cnt",  32'(u0.div_cnt_q),  32'd0);
    end
    @(posedge clk);
    #1 a.en = 1'b1;
    @(negedge clk);
    chk("resume_no_tick_yet", 32'(a.pix_tick), 32'd0);
    @(negedge clk);
    chk("resume_tick",        32'(a.pix_tick), 32'd1);
    chk("resume_tick_hcount", 32'(a.hcount),   32'd100);
    @(negedge clk);
    chk("resume_advanced",    32'(a.hcount),   32'd101);

    // Reset mid-line while hsync is active.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (a.hcount != 10'd700 && n < 2000);
    chk("reach_h700",      32'(a.hcount),   32'd700);
    chk("hsync_act_h700",  32'(a.hsync),    32'd0);
    chk("video_off_h700",  32'(a.video_on), 32'd0);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_hcount",   32'(a.hcount),   32'd0);
    chk("midrst_vcount",   32'(a.vcount),   32'd0);
    chk("midrst_hsync",    32'(a.hsync),    32'd1);
    chk("midrst_video_on", 32'(a.video_on), 32'd1);
    rst0 = 1'b0;

    // Small raster, CLK_DIV=1: two full frames of 15x9 pixels.
    b.en = 1'b1;
    @(posedge clk);
    #1 rst1 = 1'b0;
    chk("b_rst_hcount",  32'(b.hcount),   32'd0);
    chk("b_rst_vcount",  32'(b.vcount),   32'd0);
    chk("b_tick_is_en",  32'(b.pix_tick), 32'd1);
    chk("b_rst_hsync",   32'(b.hsync),    32'd1);
    chk("b_rst_vsync",   32'(b.vsync),    32'd1);
    fe_n = 0; le_n = 0; vsl_n = 0; hsl_n = 0; von_n = 0;
    repeat (270) begin
      @(negedge clk);
      if (b.frame_end) begin
        fe_n++;
        chk("b_frame_end_pos", 32'({b.hcount, b.vcount}), 32'({10'd14, 10'd8}));
      end
      if (b.line_end) le_n++;
      if (!b.vsync)   vsl_n++;
      if (!b.hsync)   hsl_n++;
      if (b.video_on) von_n++;
    end
    chk("b_frame_end_pulses", 32'(fe_n),  32'd2);
    chk("b_line_end_pulses",  32'(le_n),  32'd18);
    chk("b_vsync_low_ticks",  32'(vsl_n), 32'd60);
    chk("b_hsync_low_ticks",  32'(hsl_n), 32'd54);
    chk("b_video_on_ticks",   32'(von_n), 32'd64);
    @(negedge clk);
    chk("b_wrap_hcount", 32'(b.hcount), 32'd0);
    chk("b_wrap_vcount", 32'(b.vcount), 32'd0);

`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_two_frames", 32'(b.frame_cnt), 32'd2);
    force u1.frame_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1 release u1.frame_cnt_q;
    chk("fcnt_preload", 32'(b.frame_cnt), 32'h0000FFFF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b.frame_end && n < 300);
    chk("fcnt_frame_end_seen", 32'(b.frame_end), 32'd1);
    @(posedge clk);
    #1 chk("fcnt_wrap", 32'(b.frame_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
